// File: rtl/sonar_uc_varredura.sv
// Sonar sweep control unit: trigger, echo wait with retry, N-char frame,
// servo ping-pong step and inter-measurement wait.
module sonar_uc_varredura #(
    parameter int N_DIGITOS      = 4,
    parameter int N_POSICOES     = 8,
    parameter int TIMEOUT_MEDIDA = 1_000_000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int INTERVALO      = 2_000_000,
    localparam int DW = (N_DIGITOS > 2) ? $clog2(N_DIGITOS) : 1,
    localparam int PW = (N_POSICOES > 2) ? $clog2(N_POSICOES) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ligar,
    input  logic          modo_unico,
    input  logic          fim_medida,
    input  logic          fim_transmissao,
    output logic          zera,
    output logic          medir_distancia,
    output logic          transmitir,
    output logic [DW-1:0] indice_digito,
    output logic [PW-1:0] posicao,
    output logic          sentido,
    output logic          erro_medida,
    output logic          pronto,
    output logic [3:0]    db_estado
);

    localparam int TW = (TIMEOUT_MEDIDA > 2) ? $clog2(TIMEOUT_MEDIDA) : 1;
    localparam int IW = (INTERVALO > 2) ? $clog2(INTERVALO) : 1;
    localparam int AW = $clog2(MAX_TENTATIVAS + 1);

    localparam logic [3:0] S_INICIAL   = 4'h0;
    localparam logic [3:0] S_PREP      = 4'h1;
    localparam logic [3:0] S_MEDIR     = 4'h2;
    localparam logic [3:0] S_ESP_MED   = 4'h3;
    localparam logic [3:0] S_TX        = 4'h4;
    localparam logic [3:0] S_ESP_TX    = 4'h5;
    localparam logic [3:0] S_PROX_DIG  = 4'h6;
    localparam logic [3:0] S_PROX_POS  = 4'h7;
    localparam logic [3:0] S_ESP_INT   = 4'h8;
    localparam logic [3:0] S_FALHA     = 4'h9;
    localparam logic [3:0] S_FIM       = 4'hA;

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] tent_q, tent_d;
    logic [IW-1:0] int_q, int_d;
    logic [DW-1:0] indice_q, indice_d;
    logic [PW-1:0] posicao_q, posicao_d;
    logic          sentido_q, sentido_d;
    logic          erro_q, erro_d;
    logic          modo_q, modo_d;

    logic timeout, ultima, ultimo_dig, int_fim;

    assign timeout    = (state_q == S_ESP_MED) && (tmo_q == TW'(TIMEOUT_MEDIDA - 1));
    assign ultima     = (tent_q == AW'(MAX_TENTATIVAS - 1));
    assign ultimo_dig = (indice_q == DW'(N_DIGITOS - 1));
    assign int_fim    = (int_q == IW'(INTERVALO - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_INICIAL;
            tmo_q     <= '0;
            tent_q    <= '0;
            int_q     <= '0;
            indice_q  <= '0;
            posicao_q <= '0;
            sentido_q <= 1'b0;
            erro_q    <= 1'b0;
            modo_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            tent_q    <= tent_d;
            int_q     <= int_d;
            indice_q  <= indice_d;
            posicao_q <= posicao_d;
            sentido_q <= sentido_d;
            erro_q    <= erro_d;
            modo_q    <= modo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INICIAL:  if (ligar) state_d = S_PREP;
            S_PREP:     state_d = ligar ? S_MEDIR : S_INICIAL;
            S_MEDIR:    state_d = S_ESP_MED;
            S_ESP_MED: begin
                // a measurement arriving in the timeout cycle wins
                if (fim_medida)   state_d = S_TX;
                else if (timeout) state_d = ultima ? S_FALHA : S_MEDIR;
            end
            S_FALHA:    state_d = S_TX;
            S_TX:       state_d = S_ESP_TX;
            S_ESP_TX: begin
                if (fim_transmissao) begin
                    if (!ultimo_dig) state_d = S_PROX_DIG;
                    else if (modo_q) state_d = S_FIM;
                    else             state_d = S_PROX_POS;
                end
            end
            S_PROX_DIG: state_d = S_TX;
            S_PROX_POS: state_d = S_ESP_INT;
            S_ESP_INT:  if (int_fim) state_d = ligar ? S_PREP : S_INICIAL;
            S_FIM:      if (!ligar) state_d = S_INICIAL;
            default:    state_d = S_INICIAL;
        endcase
    end

    always_comb begin
        tmo_d     = tmo_q;
        tent_d    = tent_q;
        int_d     = int_q;
        indice_d  = indice_q;
        posicao_d = posicao_q;
        sentido_d = sentido_q;
        erro_d    = erro_q;
        modo_d    = modo_q;
        unique case (state_q)
            S_INICIAL: begin
                posicao_d = '0;
                sentido_d = 1'b0;
                erro_d    = 1'b0;
                if (ligar) modo_d = modo_unico;
            end
            S_PREP: begin
                tent_d   = '0;
                indice_d = '0;
                erro_d   = 1'b0;
            end
            S_MEDIR:    tmo_d = '0;
            S_ESP_MED: begin
                tmo_d = tmo_q + TW'(1);
                if (timeout && !fim_medida) begin
                    tent_d = tent_q + AW'(1);
                    if (ultima) erro_d = 1'b1;
                end
            end
            S_PROX_DIG: indice_d = indice_q + DW'(1);
            S_PROX_POS: begin
                int_d = '0;
                // ping-pong: bounce off either end without repeating it
                if (!sentido_q) begin
                    if (posicao_q == PW'(N_POSICOES - 1)) begin
                        sentido_d = 1'b1;
                        posicao_d = PW'(N_POSICOES - 2);
                    end else begin
                        posicao_d = posicao_q + PW'(1);
                    end
                end else begin
                    if (posicao_q == '0) begin
                        sentido_d = 1'b0;
                        posicao_d = PW'(1);
                    end else begin
                        posicao_d = posicao_q - PW'(1);
                    end
                end
            end
            S_ESP_INT:  int_d = int_q + IW'(1);
            default: ;
        endcase
    end

    always_comb begin
        zera            = (state_q == S_INICIAL) || (state_q == S_PREP);
        medir_distancia = (state_q == S_MEDIR);
        transmitir      = (state_q == S_TX);
        pronto          = (state_q == S_FIM);
        indice_digito   = indice_q;
        posicao         = posicao_q;
        sentido         = sentido_q;
        erro_medida     = erro_q;
        db_estado       = (state_q <= S_FIM) ? state_q : 4'hF;
    end

endmodule
